// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit queue.
// Holds the launch FSM encoding and pointer width helper.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_DONE
   } txq_state_e;

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_tx_queue_if.sv
// Host write port plus uart_fd transmit side of the queue.
// frames_sent exists only with UART_TX_QUEUE_STATS_EN.
interface uart_tx_queue_if #(
   parameter int DEPTH = 16
);
   import uart_pkg::*;

   localparam int PW = ptr_w(DEPTH);

   logic                   wr_en;
   logic [UART_DATA_W-1:0] wr_data;
   logic                   full;
   logic                   empty;
   logic [PW-1:0]          level;
   logic                   overflow;
   logic                   start_err;
   logic                   tx_busy;
   logic                   tx_start;
   logic [UART_DATA_W-1:0] tx_data;
`ifdef UART_TX_QUEUE_STATS_EN
   logic [15:0]            frames_sent;
`endif

   modport master (
      output wr_en, wr_data, tx_busy,
      input  full, empty, level, overflow,
      input  start_err, tx_start, tx_data
`ifdef UART_TX_QUEUE_STATS_EN
      , input frames_sent
`endif
   );

   modport slave (
      input  wr_en, wr_data, tx_busy,
      output full, empty, level, overflow,
      output start_err, tx_start, tx_data
`ifdef UART_TX_QUEUE_STATS_EN
      , output frames_sent
`endif
   );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered read-on-pop.
// Level, full and empty are registered from the post-update pointers.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_,
   input  logic                      push,
   input  logic [W-1:0]              din,
   input  logic                      pop,
   output logic [W-1:0]              dout,
   output logic                      full,
   output logic                      empty,
   output logic [ptr_w(DEPTH)-1:0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_w(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wp, rp;
   logic [PW-1:0] wp_n, rp_n, lvl_n;
   logic          do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign wp_n    = wp + PW'(do_push);
   assign rp_n    = rp + PW'(do_pop);
   assign lvl_n   = wp_n - rp_n;

   always_ff @(posedge clk) begin
      if (do_push) mem[wp[AW-1:0]] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst_) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
         dout  <= '0;
      end else begin
         if (do_pop) dout <= mem[rp[AW-1:0]];
         wp    <= wp_n;
         rp    <= rp_n;
         level <= lvl_n;
         full  <= (lvl_n == PW'(DEPTH));
         empty <= (lvl_n == '0);
      end
   end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and launch FSM feeding uart_fd tx_start/tx_data.
// Optional UART_TX_QUEUE_STATS_EN adds frames_sent and a data-stability check.
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DEPTH         = 16,
   parameter int START_TIMEOUT = 16
) (
   input logic       clk,
   input logic       rst_,
   uart_tx_queue_if.slave q
);

   localparam int TW = $clog2(START_TIMEOUT) + 1;

   txq_state_e    state;
   logic [TW-1:0] cnt;
   logic          pop;

   assign pop = (state == IDLE) && !q.empty && !q.tx_busy;

   uart_sync_fifo #(
      .W     (UART_DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_  (rst_),
      .push  (q.wr_en),
      .din   (q.wr_data),
      .pop   (pop),
      .dout  (q.tx_data),
      .full  (q.full),
      .empty (q.empty),
      .level (q.level)
   );

   always_ff @(posedge clk) begin
      if (rst_) begin
         state       <= IDLE;
         cnt         <= '0;
         q.tx_start  <= 1'b0;
         q.overflow  <= 1'b0;
         q.start_err <= 1'b0;
      end else begin
         if (q.wr_en && q.full) q.overflow <= 1'b1;
         unique case (state)
            IDLE: begin
               if (pop) begin
                  q.tx_start <= 1'b1;
                  cnt        <= '0;
                  state      <= LAUNCH;
               end
            end
            LAUNCH: begin
               if (q.tx_busy) begin
                  q.tx_start <= 1'b0;
                  state      <= WAIT_DONE;
               end else if (cnt == TW'(START_TIMEOUT - 1)) begin
                  // uart_fd never answered: the popped byte is dropped
                  q.tx_start  <= 1'b0;
                  q.start_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!q.tx_busy) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef UART_TX_QUEUE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst_)
         q.frames_sent <= '0;
      else if (state == LAUNCH && q.tx_busy)
         q.frames_sent <= q.frames_sent + 16'd1;
   end

   a_data_stable: assert property (
      @(posedge clk) disable iff (rst_)
      (q.tx_start || q.tx_busy) &&
      $past(q.tx_start || q.tx_busy) && !$past(rst_)
      |-> $stable(q.tx_data));
`endif

endmodule
